filt_oup_requant: RTL

- Downstream stage of the MAC FIR filter. Consumes the filter's full-precision signed result whenever its done strobe fires.
- Processing per result: round, arithmetic shift, saturate to a narrow output word, then optional decimation.
- Results are buffered in a small FIFO and presented on a valid/ready interface to the next consumer (DAC formatter or capture logic).

---
 rtl/filt_oup_requant.sv | 121 ++++++++++++
 1 files changed

// File: rtl/filt_oup_requant.sv
// Requantiser behind the MAC FIR: round, shift, saturate, decimate, then buffer in a FWFT FIFO.
// Define REQUANT_STATS_EN to add saturating saturation/drop event counters.
module filt_oup_requant #(
   parameter int gp_inp_width  = 37,
   parameter int gp_oup_width  = 16,
   parameter int gp_shift      = 12,
   parameter int gp_decim      = 2,
   parameter int gp_fifo_depth = 4
) (
   input  logic                           i_clk,
   input  logic                           i_rst_an,
   input  logic                           i_ena,
   input  logic signed [gp_inp_width-1:0] i_data,
   input  logic                           i_done,
   output logic signed [gp_oup_width-1:0] o_data,
   output logic                           o_valid,
   input  logic                           i_ready,
   output logic                           o_sat,
   output logic                           o_drop
`ifdef REQUANT_STATS_EN
   ,
   output logic [15:0]                    o_sat_cnt,
   output logic [15:0]                    o_drop_cnt
`endif
);

   localparam int W1 = gp_inp_width + 1;
   localparam int AW = $clog2(gp_fifo_depth);
   localparam int DW = (gp_decim > 1) ? $clog2(gp_decim) : 1;

   // Half an output LSB; evaluates to zero when no shift is applied.
   localparam logic signed [W1-1:0] RND  = W1'((64'd1 << gp_shift) >> 1);
   localparam logic signed [W1-1:0] SMAX = W1'((64'sd1 <<< (gp_oup_width-1)) - 64'sd1);
   localparam logic signed [W1-1:0] SMIN = W1'(-(64'sd1 <<< (gp_oup_width-1)));

   logic signed [W1-1:0]           r1;
   logic                           r1_vld;
   logic signed [W1-1:0]           s;
   logic                           sat_hi, sat_lo;
   logic [gp_oup_width-1:0]        q;
   logic [DW-1:0]                  dec_cnt;
   logic                           keep;

   logic [gp_oup_width-1:0]        mem [gp_fifo_depth];
   logic [AW:0]                    wptr, rptr;
   logic                           empty, full, rd, wr_req, wr, drop_ev;

   always_ff @(posedge i_clk or negedge i_rst_an) begin
      if (!i_rst_an) begin
         r1     <= '0;
         r1_vld <= 1'b0;
      end else begin
         r1_vld <= i_ena & i_done;
         if (i_ena && i_done)
            r1 <= {i_data[gp_inp_width-1], i_data} + RND;
      end
   end

   always_comb begin
      s      = r1 >>> gp_shift;
      sat_hi = (s > SMAX);
      sat_lo = (s < SMIN);
      q      = s[gp_oup_width-1:0];
      if (sat_hi)
         q = SMAX[gp_oup_width-1:0];
      else if (sat_lo)
         q = SMIN[gp_oup_width-1:0];
   end

   assign keep    = (dec_cnt == '0);
   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign o_valid = ~empty;
   assign rd      = o_valid & i_ready;
   assign wr_req  = r1_vld & keep;
   // A read on the same edge frees the slot, so a full FIFO still accepts the write.
   assign wr      = wr_req & (~full | rd);
   assign drop_ev = wr_req & full & ~rd;
   assign o_data  = o_valid ? mem[rptr[AW-1:0]] : '0;

   always_ff @(posedge i_clk or negedge i_rst_an) begin
      if (!i_rst_an) begin
         dec_cnt <= '0;
         wptr    <= '0;
         rptr    <= '0;
         o_sat   <= 1'b0;
         o_drop  <= 1'b0;
      end else begin
         if (r1_vld)
            dec_cnt <= (dec_cnt == DW'(gp_decim-1)) ? '0 : dec_cnt + DW'(1);
         if (wr)
            wptr <= wptr + 1'b1;
         if (rd)
            rptr <= rptr + 1'b1;
         if (wr_req && (sat_hi || sat_lo))
            o_sat <= 1'b1;
         if (drop_ev)
            o_drop <= 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (wr)
         mem[wptr[AW-1:0]] <= q;
   end

`ifdef REQUANT_STATS_EN
   always_ff @(posedge i_clk or negedge i_rst_an) begin
      if (!i_rst_an) begin
         o_sat_cnt  <= '0;
         o_drop_cnt <= '0;
      end else begin
         if (wr_req && (sat_hi || sat_lo) && o_sat_cnt != 16'hFFFF)
            o_sat_cnt <= o_sat_cnt + 16'd1;
         if (drop_ev && o_drop_cnt != 16'hFFFF)
            o_drop_cnt <= o_drop_cnt + 16'd1;
      end
   end
`endif

endmodule
